mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage that consumes the EX/MEM pipeline register outputs (ED_*); it reads them and drives a valid/ready data-memory port.
- Issues load/store requests to data memory, waits for the response or ack, then aligns and sign- or zero-extends load data.
- Asserts a stall toward the hazard unit so ED_* holds while an access is in flight.
- Presents M_valM_o (registered) to writeback.

Parameters:
- XLEN, 32, datapath/address width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk_i  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ED_load_op_i  in  3  load op from EX/MEM register.
- ED_store_op_i  in  2  store op from EX/MEM register.
- ED_valE_i  in  XLEN  effective address.
- ED_rs2_data_i  in  XLEN  store data.
- M_stall_o  out  1  hold ED register and upstream.
- M_valM_o  out  XLEN  aligned/extended load result.
- M_misalign_o  out  1  one-cycle pulse, misaligned access.
- M_err_o  out  1  one-cycle pulse, timeout (feature only; else tied 0).
- dmem_req_valid_o  out  1  request valid.
- dmem_req_ready_i  in  1  request accepted.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  XLEN  word address {valE[XLEN-1:2],2'b00}.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_wstrb_o  out  4  byte strobes.
- dmem_resp_valid_i  in  1  read data / write ack.
- dmem_resp_data_i  in  XLEN  read data.

Behaviour:
- Encodings:
  - load: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as NONE.
  - store: 0 NONE, 1 SB, 2 SH, 3 SW.
  - mem_op = load_op!=0 or store_op!=0. Both nonzero: load wins.
- Reset: state=IDLE. All outputs 0, counter 0.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_op and aligned: go to REQ.
  - mem_op and misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): pulse M_misalign_o, issue no request, go to DONE with M_valM_o=0.
  - Otherwise stay in IDLE.
- REQ:
  - dmem_req_valid_o=1.
  - addr, we, wdata and wstrb are registered at IDLE→REQ and held stable until ready.
  - ready=1: go to WAIT (request accepted that edge).
- WAIT:
  - dmem_resp_valid_i=1: capture data, go to DONE.
  - resp_valid is ignored in every state other than WAIT.
  - A response is never expected in the same cycle as acceptance.
- DONE:
  - M_valM_o is valid here; stall deasserted.
  - Unconditionally go to IDLE next edge; ED advances on that same edge.
- M_stall_o (combinational) = mem_op and state != DONE. It is 0 for non-memory instructions: zero added latency.
- Latency: a load completes in 3 + (ready wait) + (response wait) cycles after ED presents it. Minimum is IDLE, REQ, WAIT, DONE = 4 cycles of occupancy.
- Store strobes and write data:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: wstrb = 4'b0011<<{addr[1],1'b0}, wdata = half replicated ×2.
  - SW: wstrb = 4'b1111.
- Stores go through the same FSM; resp_valid is the write ack. M_valM_o for a store = 0.
- Load data: sh = resp_data>>(addr[1:0]*8).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: resp_data.
- M_valM_o holds its value until the next DONE.
- Reset mid-access (REQ/WAIT):
  - Go to IDLE and drop the transaction. A late response is ignored.
  - dmem_req_valid_o goes low the cycle after rst.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter increments each cycle in REQ or WAIT and clears on leaving them.
  - Reaching TIMEOUT_CYCLES: req_valid drops, M_err_o pulses one cycle, M_valM_o=0, go to DONE.
- Undefined: no counter; the stage waits indefinitely; M_err_o tied 0.

Decomposition:
- Shared package/define file: the load/store encodings and widths LOAD_WIDTH=3 and STORE_WIDTH=2, state encodings, XLEN.
- One natural sub-module, mem_align: combinational store lane/strobe generation plus load extraction and extension. The FSM stays in the parent.

Test Plan:
- LW addr 0x100, ready=1 immediately, resp 0xDEADBEEF one cycle later:
  - req_valid for 1 cycle, addr 0x100, wstrb 4'b0000.
  - M_valM_o=0xDEADBEEF in DONE.
  - Stall high for exactly 3 cycles.
- LB addr 0x103, resp 0x80FFFFFF → M_valM_o=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH addr 0x102, rs2=0x1234ABCD → wdata=0xABCDABCD, wstrb=4'b1100, we=1. Completes on ack; M_valM_o=0.
- LW addr 0x101 → M_misalign_o pulses once, no req_valid, stall for 1 cycle.
- Ready held low 5 cycles, then rst asserted during WAIT, with resp_valid arriving after reset:
  - Addr/wdata stay stable while ready is low.
  - After rst: state IDLE, outputs 0, the late response is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response → M_err_o pulses at cycle 8, M_valM_o=0, stall released.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory access stage: load/store op codes,
// FSM state encoding, datapath width and small decode helpers.
package mem_access_stage_pkg;

   localparam int XLEN        = 32;
   localparam int LOAD_WIDTH  = 3;
   localparam int STORE_WIDTH = 2;

   typedef enum logic [LOAD_WIDTH-1:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LH   = 3'd2,
      LD_LW   = 3'd3,
      LD_LBU  = 3'd4,
      LD_LHU  = 3'd5
   } load_op_e;

   typedef enum logic [STORE_WIDTH-1:0] {
      ST_NONE = 2'd0,
      ST_SB   = 2'd1,
      ST_SH   = 2'd2,
      ST_SW   = 2'd3
   } store_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Codes 6 and 7 decode as no load.
   function automatic logic is_load(input logic [LOAD_WIDTH-1:0] op);
      return (op != LD_NONE) && (op <= LD_LHU);
   endfunction

   // Halfword ops need addr[0]=0, word ops need addr[1:0]=0. Load wins over store.
   function automatic logic is_misaligned(input logic [LOAD_WIDTH-1:0]  ld_op,
                                          input logic [STORE_WIDTH-1:0] st_op,
                                          input logic [1:0]             lane);
      logic mis;
      mis = 1'b0;
      if (is_load(ld_op)) begin
         if (ld_op == LD_LH || ld_op == LD_LHU) mis = lane[0];
         else if (ld_op == LD_LW)               mis = (lane != 2'b00);
      end else begin
         if (st_op == ST_SH)      mis = lane[0];
         else if (st_op == ST_SW) mis = (lane != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane helper: store lane replication and strobes, plus load lane
// extraction with sign/zero extension. Purely combinational.
module mem_access_stage_align
   import mem_access_stage_pkg::*;
#(
   parameter int XLEN = mem_access_stage_pkg::XLEN
) (
   input  logic [STORE_WIDTH-1:0] st_op_i,
   input  logic [1:0]             st_lane_i,
   input  logic [XLEN-1:0]        st_data_i,
   input  logic [LOAD_WIDTH-1:0]  ld_op_i,
   input  logic [1:0]             ld_lane_i,
   input  logic [XLEN-1:0]        rdata_i,
   output logic [XLEN-1:0]        wdata_o,
   output logic [3:0]             wstrb_o,
   output logic [XLEN-1:0]        ldata_o
);

   function automatic logic [XLEN-1:0] ext_byte(input logic signed [7:0] b, input logic sgn);
      logic signed [XLEN-1:0] s;
      s = XLEN'(b);
      return sgn ? s : {{(XLEN-8){1'b0}}, b};
   endfunction

   function automatic logic [XLEN-1:0] ext_half(input logic signed [15:0] h, input logic sgn);
      logic signed [XLEN-1:0] s;
      s = XLEN'(h);
      return sgn ? s : {{(XLEN-16){1'b0}}, h};
   endfunction

   logic [XLEN-1:0] sh;

   // Store side: replicate the written lane across the word and select strobes.
   always_comb begin
      wdata_o = '0;
      wstrb_o = 4'b0000;
      case (st_op_i)
         ST_SB: begin
            wdata_o = {(XLEN/8){st_data_i[7:0]}};
            wstrb_o = 4'b0001 << st_lane_i;
         end
         ST_SH: begin
            wdata_o = {(XLEN/16){st_data_i[15:0]}};
            wstrb_o = 4'b0011 << {st_lane_i[1], 1'b0};
         end
         ST_SW: begin
            wdata_o = st_data_i;
            wstrb_o = 4'b1111;
         end
         default: ;
      endcase
   end

   // Load side: shift the addressed lane down, then extend to full width.
   always_comb begin
      sh      = rdata_i >> {ld_lane_i, 3'b000};
      ldata_o = '0;
      case (ld_op_i)
         LD_LB:   ldata_o = ext_byte(sh[7:0], 1'b1);
         LD_LBU:  ldata_o = ext_byte(sh[7:0], 1'b0);
         LD_LH:   ldata_o = ext_half(sh[15:0], 1'b1);
         LD_LHU:  ldata_o = ext_half(sh[15:0], 1'b0);
         LD_LW:   ldata_o = sh;
         default: ldata_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: runs ED_* loads/stores over a valid/ready data-memory
// port, stalls upstream while an access is in flight and registers the
// aligned load result for writeback.
// Optional build macro MEM_TIMEOUT_EN adds a REQ/WAIT watchdog (M_err_o).
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int XLEN           = mem_access_stage_pkg::XLEN,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk_i,
   input  logic                   rst,
   input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
   input  logic [STORE_WIDTH-1:0] ED_store_op_i,
   input  logic [XLEN-1:0]        ED_valE_i,
   input  logic [XLEN-1:0]        ED_rs2_data_i,
   output logic                   M_stall_o,
   output logic [XLEN-1:0]        M_valM_o,
   output logic                   M_misalign_o,
   output logic                   M_err_o,
   output logic                   dmem_req_valid_o,
   input  logic                   dmem_req_ready_i,
   output logic                   dmem_we_o,
   output logic [XLEN-1:0]        dmem_addr_o,
   output logic [XLEN-1:0]        dmem_wdata_o,
   output logic [3:0]             dmem_wstrb_o,
   input  logic                   dmem_resp_valid_i,
   input  logic [XLEN-1:0]        dmem_resp_data_i
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e                  state_q;
   logic                    req_valid_q;
   logic                    we_q;
   logic [XLEN-1:0]         addr_q;
   logic [XLEN-1:0]         wdata_q;
   logic [3:0]              wstrb_q;
   logic [LOAD_WIDTH-1:0]   ld_op_q;
   logic [1:0]              lane_q;
   logic [XLEN-1:0]         valm_q;
   logic                    misalign_q;

   logic                    ed_is_ld;
   logic                    mem_op;
   logic                    ed_mis;
   logic [STORE_WIDTH-1:0]  st_op_eff;
   logic [XLEN-1:0]         wdata_c;
   logic [3:0]              wstrb_c;
   logic [XLEN-1:0]         ldata_c;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        cnt_q;
   logic                    err_q;
`endif

   assign ed_is_ld  = is_load(ED_load_op_i);
   assign mem_op    = ed_is_ld || (ED_store_op_i != ST_NONE);
   assign ed_mis    = is_misaligned(ED_load_op_i, ED_store_op_i, ED_valE_i[1:0]);
   // A load shadows any simultaneous store code.
   assign st_op_eff = ed_is_ld ? ST_NONE : ED_store_op_i;

   mem_access_stage_align #(.XLEN(XLEN)) u_align (
      .st_op_i   (st_op_eff),
      .st_lane_i (ED_valE_i[1:0]),
      .st_data_i (ED_rs2_data_i),
      .ld_op_i   (ld_op_q),
      .ld_lane_i (lane_q),
      .rdata_i   (dmem_resp_data_i),
      .wdata_o   (wdata_c),
      .wstrb_o   (wstrb_c),
      .ldata_o   (ldata_c)
   );

   // Access FSM: launch request, await acceptance, await response, present result.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_valid_q <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= 4'b0000;
         ld_op_q     <= LD_NONE;
         lane_q      <= 2'b00;
         valm_q      <= '0;
         misalign_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (mem_op) begin
                  if (ed_mis) begin
                     misalign_q <= 1'b1;
                     valm_q     <= '0;
                     state_q    <= S_DONE;
                  end else begin
                     req_valid_q <= 1'b1;
                     we_q        <= !ed_is_ld;
                     addr_q      <= {ED_valE_i[XLEN-1:2], 2'b00};
                     wdata_q     <= wdata_c;
                     wstrb_q     <= wstrb_c;
                     ld_op_q     <= ed_is_ld ? ED_load_op_i : LD_NONE;
                     lane_q      <= ED_valE_i[1:0];
                     state_q     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (dmem_req_ready_i) begin
                  req_valid_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_resp_valid_i) begin
                  valm_q  <= we_q ? '0 : ldata_c;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef MEM_TIMEOUT_EN
         if (state_q == S_REQ || state_q == S_WAIT) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) &&
                !(state_q == S_WAIT && dmem_resp_valid_i)) begin
               req_valid_q <= 1'b0;
               err_q       <= 1'b1;
               valm_q      <= '0;
               state_q     <= S_DONE;
               cnt_q       <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
`endif
      end
   end

   assign M_stall_o        = mem_op && (state_q != S_DONE);
   assign M_valM_o         = valm_q;
   assign M_misalign_o     = misalign_q;
   assign dmem_req_valid_o = req_valid_q;
   assign dmem_we_o        = we_q;
   assign dmem_addr_o      = addr_q;
   assign dmem_wdata_o     = wdata_q;
   assign dmem_wstrb_o     = wstrb_q;
`ifdef MEM_TIMEOUT_EN
   assign M_err_o          = err_q;
`else
   assign M_err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

   logic        clk_i = 1'b0;
   logic        rst;
   logic [2:0]  ED_load_op_i;
   logic [1:0]  ED_store_op_i;
   logic [31:0] ED_valE_i;
   logic [31:0] ED_rs2_data_i;
   logic        M_stall_o;
   logic [31:0] M_valM_o;
   logic        M_misalign_o;
   logic        M_err_o;
   logic        dmem_req_valid_o;
   logic        dmem_req_ready_i;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic        dmem_resp_valid_i;
   logic [31:0] dmem_resp_data_i;

   int n_vec  = 0;
   int n_miss = 0;

   mem_access_stage dut (
      .clk_i             (clk_i),
      .rst               (rst),
      .ED_load_op_i      (ED_load_op_i),
      .ED_store_op_i     (ED_store_op_i),
      .ED_valE_i         (ED_valE_i),
      .ED_rs2_data_i     (ED_rs2_data_i),
      .M_stall_o         (M_stall_o),
      .M_valM_o          (M_valM_o),
      .M_misalign_o      (M_misalign_o),
      .M_err_o           (M_err_o),
      .dmem_req_valid_o  (dmem_req_valid_o),
      .dmem_req_ready_i  (dmem_req_ready_i),
      .dmem_we_o         (dmem_we_o),
      .dmem_addr_o       (dmem_addr_o),
      .dmem_wdata_o      (dmem_wdata_o),
      .dmem_wstrb_o      (dmem_wstrb_o),
      .dmem_resp_valid_i (dmem_resp_valid_i),
      .dmem_resp_data_i  (dmem_resp_data_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   // Presents one ED instruction and plays the memory side until the DONE cycle.
   task automatic do_access(input logic [2:0] ld, input logic [1:0] st,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rdata, input int rdy_wait,
                            output int stall_n, output int req_n,
                            output logic [31:0] q_addr, output logic [31:0] q_wdata,
                            output logic [3:0] q_wstrb, output logic q_we,
                            output logic mis_seen, output logic mis_after,
                            output logic [31:0] valm);
      logic acc_prev;
      logic done;
      stall_n = 0; req_n = 0; q_addr = '0; q_wdata = '0; q_wstrb = '0; q_we = 1'b0;
      mis_seen = 1'b0; mis_after = 1'b0; valm = '0;
      acc_prev = 1'b0; done = 1'b0;
      ED_load_op_i = ld; ED_store_op_i = st; ED_valE_i = a; ED_rs2_data_i = d;
      dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0; dmem_resp_data_i = rdata;
      #1;
      for (int cyc = 0; cyc < 50 && !done; cyc++) begin
         if (!M_stall_o) begin
            done = 1'b1;
         end else begin
            stall_n++;
            dmem_resp_valid_i = acc_prev;
            acc_prev = 1'b0;
            if (dmem_req_valid_o) begin
               req_n++;
               if (req_n == 1) begin
                  q_addr = dmem_addr_o; q_wdata = dmem_wdata_o;
                  q_wstrb = dmem_wstrb_o; q_we = dmem_we_o;
               end else begin
                  check_vec("addr_hold", dmem_addr_o, q_addr);
                  check_vec("wdata_hold", dmem_wdata_o, q_wdata);
               end
               dmem_req_ready_i = (req_n > rdy_wait);
               acc_prev = dmem_req_ready_i;
            end else begin
               dmem_req_ready_i = 1'b0;
            end
            tick();
         end
      end
      if (!done) check_vec("access_bound", 32'd0, 32'd1);
      valm = M_valM_o;
      mis_seen = M_misalign_o;
      dmem_resp_valid_i = 1'b0; dmem_req_ready_i = 1'b0;
      tick();
      mis_after = M_misalign_o;
      ED_load_op_i = '0; ED_store_op_i = '0; ED_valE_i = '0; ED_rs2_data_i = '0;
      #1;
   endtask

   int          sn, rn;
   logic [31:0] qa, qd, vm;
   logic [3:0]  qs;
   logic        qw, ms, ma;

   initial begin
      rst = 1'b1;
      ED_load_op_i = '0; ED_store_op_i = '0; ED_valE_i = '0; ED_rs2_data_i = '0;
      dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0; dmem_resp_data_i = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check_vec("rst_valM", M_valM_o, 32'h0);
      check_vec("rst_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
      check_vec("rst_stall", {31'd0, M_stall_o}, 32'd0);
      check_vec("rst_addr", dmem_addr_o, 32'h0);
      check_vec("rst_err", {31'd0, M_err_o}, 32'd0);

      // LW 0x100, immediate ready, response next cycle
      do_access(3'd3, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("lw_valM", vm, 32'hDEADBEEF);
      check_vec("lw_stall_cycles", sn, 32'd3);
      check_vec("lw_req_cycles", rn, 32'd1);
      check_vec("lw_addr", qa, 32'h100);
      check_vec("lw_wstrb", {28'd0, qs}, 32'h0);
      check_vec("lw_we", {31'd0, qw}, 32'd0);

      // LB 0x103, ready after 2 extra cycles
      do_access(3'd1, 2'd0, 32'h103, 32'h0, 32'h80FFFFFF, 2, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("lb_valM", vm, 32'hFFFFFF80);
      check_vec("lb_stall_cycles", sn, 32'd5);
      check_vec("lb_addr", qa, 32'h100);

      // LBU same access
      do_access(3'd4, 2'd0, 32'h103, 32'h0, 32'h80FFFFFF, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("lbu_valM", vm, 32'h00000080);
      check_vec("valM_hold", M_valM_o, 32'h00000080);

      // SW 0x204 with ready low 5 cycles, then reset during WAIT
      ED_load_op_i = 3'd0; ED_store_op_i = 2'd3; ED_valE_i = 32'h204; ED_rs2_data_i = 32'hCAFEF00D;
      dmem_req_ready_i = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check_vec("hold_req_valid", {31'd0, dmem_req_valid_o}, 32'd1);
         check_vec("hold_addr", dmem_addr_o, 32'h204);
         check_vec("hold_wdata", dmem_wdata_o, 32'hCAFEF00D);
         tick();
      end
      check_vec("sw_wstrb", {28'd0, dmem_wstrb_o}, 32'hF);
      check_vec("sw_we", {31'd0, dmem_we_o}, 32'd1);
      dmem_req_ready_i = 1'b1;
      tick();
      dmem_req_ready_i = 1'b0;
      check_vec("wait_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
      check_vec("wait_stall", {31'd0, M_stall_o}, 32'd1);
      rst = 1'b1;
      ED_store_op_i = '0; ED_valE_i = '0; ED_rs2_data_i = '0;
      tick();
      rst = 1'b0;
      #1;
      check_vec("rst2_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
      check_vec("rst2_stall", {31'd0, M_stall_o}, 32'd0);
      check_vec("rst2_valM", M_valM_o, 32'h0);
      check_vec("rst2_addr", dmem_addr_o, 32'h0);
      check_vec("rst2_we", {31'd0, dmem_we_o}, 32'd0);
      dmem_resp_valid_i = 1'b1; dmem_resp_data_i = 32'h12345678;
      tick(); tick();
      dmem_resp_valid_i = 1'b0;
      check_vec("late_resp_valM", M_valM_o, 32'h0);
      check_vec("late_resp_req", {31'd0, dmem_req_valid_o}, 32'd0);

      // SH 0x102
      do_access(3'd0, 2'd2, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("sh_wdata", qd, 32'hABCDABCD);
      check_vec("sh_wstrb", {28'd0, qs}, 32'hC);
      check_vec("sh_we", {31'd0, qw}, 32'd1);
      check_vec("sh_valM", vm, 32'h0);

      // SB 0x101
      do_access(3'd0, 2'd1, 32'h101, 32'h000000A5, 32'h0, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("sb_wdata", qd, 32'hA5A5A5A5);
      check_vec("sb_wstrb", {28'd0, qs}, 32'h2);

      // LH / LHU 0x102
      do_access(3'd2, 2'd0, 32'h102, 32'h0, 32'h80017FFF, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("lh_valM", vm, 32'hFFFF8001);
      do_access(3'd5, 2'd0, 32'h102, 32'h0, 32'h80017FFF, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("lhu_valM", vm, 32'h00008001);

      // Load wins over store
      do_access(3'd3, 2'd3, 32'h300, 32'h11111111, 32'h0BADF00D, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("both_we", {31'd0, qw}, 32'd0);
      check_vec("both_wstrb", {28'd0, qs}, 32'h0);
      check_vec("both_valM", vm, 32'h0BADF00D);

      // Misaligned LW 0x101
      do_access(3'd3, 2'd0, 32'h101, 32'h0, 32'h55555555, 0, sn, rn, qa, qd, qs, qw, ms, ma, vm);
      check_vec("mis_pulse", {31'd0, ms}, 32'd1);
      check_vec("mis_pulse_end", {31'd0, ma}, 32'd0);
      check_vec("mis_req_cycles", rn, 32'd0);
      check_vec("mis_stall_cycles", sn, 32'd1);
      check_vec("mis_valM", vm, 32'h0);

      // Load code 6 is not a memory op
      ED_load_op_i = 3'd6; ED_valE_i = 32'h400;
      #1;
      check_vec("op6_stall", {31'd0, M_stall_o}, 32'd0);
      tick();
      check_vec("op6_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
      check_vec("err_idle", {31'd0, M_err_o}, 32'd0);
      ED_load_op_i = '0; ED_valE_i = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
